// File: rtl/serial_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : serial_pkg
//  Description : Definitions shared by the parallel-to-serial transmitter and
//                the matching serial-to-parallel receiver.
//                - serial_state_e       : two-state FSM encoding (IDLE/SHIFT)
//                - SERIAL_WIDTH_DEFAULT : default parallel word width
//                - serial_cnt_width()   : bit-counter width for a word width
//  Revision    : 1.0 - initial release
// ============================================================================
package serial_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } serial_state_e;

    localparam int SERIAL_WIDTH_DEFAULT = 4;

    // Width of a counter that indexes bit positions 0..width-1. It never
    // returns zero, so the counter always has at least one flop.
    function automatic int serial_cnt_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage : serial_pkg
`default_nettype wire

// File: rtl/serializador_paralelo_serial_contador_bits.sv
`default_nettype none
// ============================================================================
//  Module      : contador_bits
//  Description : Bit-position counter, modulo WIDTH. It counts 0..WIDTH-1 and
//                then holds at WIDTH-1; it never wraps on its own.
//  Ports       : clock    - rising-edge clock
//                reset    - asynchronous active-low reset (count -> 0)
//                clear    - synchronous clear to 0 (has priority over enable)
//                enable   - advance by one position
//                count    - current bit position
//                terminal - high while count == WIDTH-1
//  Revision    : 1.0 - initial release
// ============================================================================
module contador_bits
    import serial_pkg::*;
#(
    parameter int WIDTH = SERIAL_WIDTH_DEFAULT
) (
    input  logic                                 clock,
    input  logic                                 reset,
    input  logic                                 clear,
    input  logic                                 enable,
    output logic [serial_cnt_width(WIDTH)-1:0]   count,
    output logic                                 terminal
);

    localparam int                CNT_W  = serial_cnt_width(WIDTH);
    localparam logic [CNT_W-1:0]  c_last = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0]  c_one  = CNT_W'(1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable && (count_q != c_last)) begin
            // Saturates at the last position; the owner clears it.
            count_d = count_q + c_one;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count    = count_q;
    assign terminal = (count_q == c_last);

endmodule : contador_bits
`default_nettype wire

// File: rtl/serializador_paralelo_serial.sv
`default_nettype none
// ============================================================================
//  Module      : serializador_paralelo_serial
//  Description : Parallel-to-serial converter. A WIDTH-bit word is accepted
//                when load and ready are both high on a rising edge. Its
//                bits appear on serial_out one per cycle, starting in the
//                next cycle. The order is MSB first (MSB_FIRST=1) or LSB
//                first (MSB_FIRST=0). A new word may be accepted during the
//                last-bit cycle, so words can be streamed with no gap.
//  Ports       : clock        - rising-edge clock
//                reset        - asynchronous active-low reset
//                load         - parallel word valid request
//                data_in      - parallel word, sampled only on acceptance
//                ready        - a word can be accepted this cycle
//                serial_out   - current serial bit (registered)
//                serial_valid - serial_out carries a valid bit (registered)
//                done         - high during the last bit of each word
//  Revision    : 1.0 - initial release
// ============================================================================
module serializador_paralelo_serial
    import serial_pkg::*;
#(
    parameter int WIDTH     = SERIAL_WIDTH_DEFAULT,  // legal range 2..32
    parameter int MSB_FIRST = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] data_in,
    output logic             ready,
    output logic             serial_out,
    output logic             serial_valid,
    output logic             done
);

    localparam int               CNT_W         = serial_cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] c_before_last = CNT_W'(WIDTH - 2);

    serial_state_e    state_q;
    serial_state_e    state_d;
    logic [WIDTH-1:0] shreg_q;
    logic [WIDTH-1:0] shreg_d;
    logic             serial_valid_q;
    logic             serial_valid_d;
    logic             done_q;
    logic             done_d;

    logic             cnt_clear;
    logic             cnt_enable;
    logic             cnt_terminal;
    logic [CNT_W-1:0] cnt_value;

    logic             w_ready;
    logic             w_accept;
    logic             w_out_bit;
    logic [WIDTH-1:0] w_shreg_shifted;

    // The bit on serial_out is always the outgoing end of the shift
    // register, so serial_out comes straight from a flop. Shifting moves the
    // next bit to that end. Clearing the register on return to IDLE makes
    // serial_out read 0 there.
    generate
        if (MSB_FIRST != 0) begin : g_msb_first
            assign w_out_bit       = shreg_q[WIDTH-1];
            assign w_shreg_shifted = {shreg_q[WIDTH-2:0], 1'b0};
        end else begin : g_lsb_first
            assign w_out_bit       = shreg_q[0];
            assign w_shreg_shifted = {1'b0, shreg_q[WIDTH-1:1]};
        end
    endgenerate

    contador_bits #(
        .WIDTH    (WIDTH)
    ) u_cnt (
        .clock    (clock),
        .reset    (reset),
        .clear    (cnt_clear),
        .enable   (cnt_enable),
        .count    (cnt_value),
        .terminal (cnt_terminal)
    );

    // Ready while idle, and during the last-bit cycle so that back-to-back
    // words follow each other without a gap.
    assign w_ready  = (state_q == IDLE) || ((state_q == SHIFT) && cnt_terminal);
    assign w_accept = load && w_ready;

    always_comb begin
        state_d        = state_q;
        shreg_d        = shreg_q;
        serial_valid_d = 1'b0;
        done_d         = 1'b0;
        cnt_clear      = 1'b0;
        cnt_enable     = 1'b0;

        if (w_accept) begin
            // The captured word's first bit is visible in the next cycle.
            state_d        = SHIFT;
            shreg_d        = data_in;
            serial_valid_d = 1'b1;
            cnt_clear      = 1'b1;
        end else if (state_q == SHIFT) begin
            if (cnt_terminal) begin
                state_d   = IDLE;
                shreg_d   = '0;
                cnt_clear = 1'b1;
            end else begin
                shreg_d        = w_shreg_shifted;
                serial_valid_d = 1'b1;
                cnt_enable     = 1'b1;
                // done is registered, so set it one position early to line
                // it up with the last bit.
                done_d         = (cnt_value == c_before_last);
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q        <= IDLE;
            shreg_q        <= '0;
            serial_valid_q <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            shreg_q        <= shreg_d;
            serial_valid_q <= serial_valid_d;
            done_q         <= done_d;
        end
    end

    assign ready        = w_ready;
    assign serial_out   = w_out_bit;
    assign serial_valid = serial_valid_q;
    assign done         = done_q;

endmodule : serializador_paralelo_serial
`default_nettype wire

// File: tb/tb_serializador_paralelo_serial.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serializador_paralelo_serial
//  Description : Self-checking bench for serializador_paralelo_serial.
//                Instance dut_a: WIDTH=4, MSB first (vector table, reset
//                sequence, random run against a queue-based model).
//                Instance dut_l: WIDTH=4, LSB first.
//                Instance dut_w: WIDTH=8, MSB first.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_serializador_paralelo_serial;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       load_a = 1'b0;
    logic [3:0] data_a = '0;
    logic       ready_a, out_a, valid_a, done_a;
    logic       load_l = 1'b0;
    logic [3:0] data_l = '0;
    logic       ready_l, out_l, valid_l, done_l;
    logic       load_w = 1'b0;
    logic [7:0] data_w = '0;
    logic       ready_w, out_w, valid_w, done_w;

    int total = 0;
    int bad   = 0;

    serializador_paralelo_serial #(.WIDTH(4), .MSB_FIRST(1)) dut_a (
        .clock(clk), .reset(rst_n), .load(load_a), .data_in(data_a),
        .ready(ready_a), .serial_out(out_a), .serial_valid(valid_a), .done(done_a));

    serializador_paralelo_serial #(.WIDTH(4), .MSB_FIRST(0)) dut_l (
        .clock(clk), .reset(rst_n), .load(load_l), .data_in(data_l),
        .ready(ready_l), .serial_out(out_l), .serial_valid(valid_l), .done(done_l));

    serializador_paralelo_serial #(.WIDTH(8), .MSB_FIRST(1)) dut_w (
        .clock(clk), .reset(rst_n), .load(load_w), .data_in(data_w),
        .ready(ready_w), .serial_out(out_w), .serial_valid(valid_w), .done(done_w));

    typedef struct {
        logic       load;
        logic [3:0] data;
        logic       e_out;
        logic       e_valid;
        logic       e_done;
        logic       e_ready;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_a(input string tag, input logic eo, input logic ev,
                         input logic ed, input logic er);
        chk({tag, ".out"},   {31'd0, out_a},   {31'd0, eo});
        chk({tag, ".valid"}, {31'd0, valid_a}, {31'd0, ev});
        chk({tag, ".done"},  {31'd0, done_a},  {31'd0, ed});
        chk({tag, ".ready"}, {31'd0, ready_a}, {31'd0, er});
    endtask

    // Drive inputs on the falling edge, check just after the rising edge.
    task automatic step_a(input logic ld, input logic [3:0] d, input logic eo,
                          input logic ev, input logic ed, input logic er, input string tag);
        @(negedge clk);
        load_a = ld;
        data_a = d;
        @(posedge clk);
        #1;
        chk_a(tag, eo, ev, ed, er);
    endtask

    initial begin
        logic exp_l [4];
        logic exp_w [8];
        logic mq [$];
        logic e_out, e_valid, e_done, e_ready;
        bit   do_rst;
        int   done_cnt;

        // ---------------- reset state ----------------
        @(posedge clk);
        #1;
        chk_a("reset_a", 1'b0, 1'b0, 1'b0, 1'b1);
        chk("reset_l.ready", {31'd0, ready_l}, 32'd1);
        chk("reset_l.valid", {31'd0, valid_l}, 32'd0);
        chk("reset_w.ready", {31'd0, ready_w}, 32'd1);
        chk("reset_w.out",   {31'd0, out_w},   32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // ---------------- vector table ----------------
        // single word 1011 from IDLE
        vecs.push_back('{1'b1, 4'b1011, 1'b1, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 4'b0000, 1'b1, 1'b1, 1'b1, 1'b1});
        vecs.push_back('{1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1});
        // back-to-back 1100 then 0011
        vecs.push_back('{1'b1, 4'b1100, 1'b1, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 4'b0000, 1'b0, 1'b1, 1'b1, 1'b1});
        vecs.push_back('{1'b1, 4'b0011, 1'b0, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 4'b0000, 1'b1, 1'b1, 1'b1, 1'b1});
        vecs.push_back('{1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1});
        // busy load of 1111 while 0001 is shifting, then data wiggle in idle
        vecs.push_back('{1'b1, 4'b0001, 1'b0, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 4'b1111, 1'b0, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 4'b1111, 1'b0, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 4'b0000, 1'b1, 1'b1, 1'b1, 1'b1});
        vecs.push_back('{1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1});
        vecs.push_back('{1'b0, 4'b1111, 1'b0, 1'b0, 1'b0, 1'b1});
        vecs.push_back('{1'b0, 4'b0101, 1'b0, 1'b0, 1'b0, 1'b1});

        for (int i = 0; i < vecs.size(); i++) begin
            step_a(vecs[i].load, vecs[i].data, vecs[i].e_out, vecs[i].e_valid,
                   vecs[i].e_done, vecs[i].e_ready, $sformatf("vec%0d", i));
        end

        // ---------------- mid-word reset ----------------
        step_a(1'b1, 4'b1010, 1'b1, 1'b1, 1'b0, 1'b0, "mrst.b0");
        step_a(1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, "mrst.b1");
        #2;
        rst_n = 1'b0;
        #1;
        chk_a("mrst.async", 1'b0, 1'b0, 1'b0, 1'b1);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        step_a(1'b1, 4'b0110, 1'b0, 1'b1, 1'b0, 1'b0, "mrst.n0");
        step_a(1'b0, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0, "mrst.n1");
        step_a(1'b0, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0, "mrst.n2");
        step_a(1'b0, 4'b0000, 1'b0, 1'b1, 1'b1, 1'b1, "mrst.n3");
        step_a(1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, "mrst.idle");

        // ---------------- LSB first: 1101 -> 1,0,1,1 ----------------
        exp_l = '{1'b1, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            load_l = (i == 0);
            data_l = (i == 0) ? 4'b1101 : 4'b0000;
            @(posedge clk);
            #1;
            chk($sformatf("lsb%0d.out", i),   {31'd0, out_l},   {31'd0, exp_l[i]});
            chk($sformatf("lsb%0d.valid", i), {31'd0, valid_l}, 32'd1);
            chk($sformatf("lsb%0d.done", i),  {31'd0, done_l},  (i == 3) ? 32'd1 : 32'd0);
        end
        @(negedge clk);
        load_l = 1'b0;
        @(posedge clk);
        #1;
        chk("lsb.idle.valid", {31'd0, valid_l}, 32'd0);

        // ---------------- WIDTH=8: A5 -> 1,0,1,0,0,1,0,1 ----------------
        exp_w = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        done_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            load_w = (i == 0);
            data_w = (i == 0) ? 8'hA5 : 8'h00;
            @(posedge clk);
            #1;
            if (done_w) done_cnt++;
            if (i < 8) begin
                chk($sformatf("w8_%0d.out", i),   {31'd0, out_w},   {31'd0, exp_w[i]});
                chk($sformatf("w8_%0d.valid", i), {31'd0, valid_w}, 32'd1);
                chk($sformatf("w8_%0d.ready", i), {31'd0, ready_w}, (i == 7) ? 32'd1 : 32'd0);
            end else begin
                chk($sformatf("w8_%0d.valid", i), {31'd0, valid_w}, 32'd0);
            end
            if (i == 7) chk("w8.count_terminal", {29'd0, dut_w.u_cnt.count}, 32'd7);
        end
        chk("w8.done_pulses", done_cnt, 32'd1);

        // ---------------- random run vs queue model ----------------
        // Model: mq holds the bits of the accepted word that are not yet on
        // serial_out. A word is accepted only when nothing is pending.
        mq.delete();
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            do_rst = ($urandom_range(0, 49) == 0);
            rst_n  = !do_rst;
            load_a = 1'($urandom_range(0, 1));
            data_a = 4'($urandom);
            if (do_rst) begin
                mq.delete();
            end else if (load_a && (mq.size() == 0)) begin
                for (int b = 3; b >= 0; b--) mq.push_back(data_a[b]);
            end
            if (!do_rst && (mq.size() > 0)) begin
                e_out   = mq.pop_front();
                e_valid = 1'b1;
                e_done  = (mq.size() == 0);
            end else begin
                e_out   = 1'b0;
                e_valid = 1'b0;
                e_done  = 1'b0;
            end
            e_ready = (mq.size() == 0);
            @(posedge clk);
            #1;
            chk_a($sformatf("rnd%0d", c), e_out, e_valid, e_done, e_ready);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_serializador_paralelo_serial
`default_nettype wire

// File: doc/serializador_paralelo_serial.md
SERIALIZADOR_PARALELO_SERIAL -- requirements
Module: serializador_paralelo_serial

Interface
REQ-001 SHALL have parameter WIDTH, default 4, meaning the parallel word width in bits; legal range 2..32.
REQ-002 SHALL have parameter MSB_FIRST, default 1, meaning 1 = shift out bit WIDTH-1 first and 0 = shift out bit 0 first.
REQ-003 SHALL have port clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: the reset; one clock; reset is asynchronous and active-low.
REQ-005 SHALL have port load, input, 1 bit: parallel word valid request.
REQ-006 SHALL have port data_in, input, WIDTH bits: parallel word, sampled only on an accepted load.
REQ-007 SHALL have port ready, output, 1 bit: block can accept a word this cycle.
REQ-008 SHALL have port serial_out, output, 1 bit: current serial bit; registered.
REQ-009 SHALL have port serial_valid, output, 1 bit: serial_out holds a valid bit; registered.
REQ-010 SHALL have port done, output, 1 bit: one-cycle pulse, high exactly in the cycle the last bit of a word is on serial_out.

Function
REQ-011 SHALL implement an FSM with states IDLE and SHIFT; reset state is IDLE.
REQ-012 SHALL define acceptance as a rising edge with load=1 and ready=1; data_in is then captured into an internal WIDTH-bit shift register.
REQ-013 SHALL drive ready=1 in IDLE, and in SHIFT only during the cycle the last bit is presented (bit counter = WIDTH-1); ready=0 otherwise.
REQ-014 SHALL have latency 1: the first bit appears on serial_out with serial_valid=1 in the cycle following acceptance.
REQ-015 SHALL present each bit for exactly one cycle; WIDTH consecutive cycles of serial_valid=1 per word; no gaps within a word.
REQ-016 SHALL track position with a bit counter of $clog2(WIDTH) bits: 0 on acceptance, +1 per shifted bit, with no wrap beyond WIDTH-1.
REQ-017 SHALL leave SHIFT for IDLE after the last bit when no load is accepted in that cycle; serial_valid=0 and serial_out=0 in IDLE.
REQ-018 SHALL, on back-to-back operation (load=1 during the last-bit cycle), accept the new word and present its first bit in the next cycle with no idle gap; done pulses for the old word only.
REQ-019 SHALL ignore load while ready=0; the in-flight word is not corrupted and data_in is not sampled.
REQ-020 SHALL treat data_in changes outside the acceptance edge as having no effect.
REQ-021 SHALL, when MSB_FIRST=0, emit bit order data_in[0] first through data_in[WIDTH-1] last, with identical timing.

Reset
REQ-022 SHALL, on reset=0 at any time, immediately force state=IDLE, shift register=0, counter=0, serial_out=0, serial_valid=0, done=0, ready=1 (combinational from IDLE).
REQ-023 SHALL, on reset asserted mid-word, discard that word with no done pulse; after release the block waits for a new load.
REQ-024 SHALL, in the first rising edge after reset release, honour an accepted load normally.

Structure
REQ-025 SHALL place the FSM state encoding (IDLE=0, SHIFT=1) and the WIDTH default constant in shared package serial_pkg, reusable by the matching serial-to-parallel receiver.
REQ-026 SHALL contain one sub-module, contador_bits (parameterised modulo-WIDTH bit counter with clear, enable and terminal-count output); everything else stays in the top module.

Verification
REQ-027 SHALL cover, with WIDTH=4 and MSB_FIRST=1: load 4'b1011 from IDLE -> serial_out 1,0,1,1 on the next 4 cycles, serial_valid high 4 cycles, done on the 4th, ready low cycles 1-3.
REQ-028 SHALL cover back-to-back: 4'b1100 then 4'b0011 loaded in the last-bit cycle -> 8 contiguous valid bits 1,1,0,0,0,0,1,1 with done on bits 4 and 8.
REQ-029 SHALL cover busy load: load=1 with data_in=4'b1111 on cycle 2 of word 4'b0001 -> output stays 0,0,0,1 and the extra word is never emitted.
REQ-030 SHALL cover mid-word reset: reset=0 after 2 bits of 4'b1010 -> outputs 0 immediately, no done, and ready=1; a subsequent load of 4'b0110 serialises correctly.
REQ-031 SHALL cover MSB_FIRST=0: load 4'b1101 -> serial_out 1,0,1,1 (LSB first), done on the 4th bit.
REQ-032 SHALL cover WIDTH=8: load 8'hA5 -> 1,0,1,0,0,1,0,1 over 8 cycles, counter terminal at 7, single done pulse.
